// File: rtl/fact_bus_master_if.sv
// Shared M_* bus between a bus initiator and the factorial-core side of the arbiter.
// Carries the level-sensitive factorial-done interrupt alongside the bus.
interface fact_bus_master_if;
   logic        M_req;
   logic        M_grant;
   logic        M_wr;
   logic [7:0]  M_address;
   logic [31:0] M_dout;
   logic [31:0] M_din;
   logic        f_interrupt;

   modport master (
      output M_req, M_wr, M_address, M_dout,
      input  M_grant, M_din, f_interrupt
   );

   modport slave (
      input  M_req, M_wr, M_address, M_dout,
      output M_grant, M_din, f_interrupt
   );
endinterface

// File: rtl/fact_bus_master.sv
// Bus initiator that runs one factorial job: program core, wait interrupt, read 64-bit result.
// Define FBM_TIMEOUT_EN to add a WAIT_INT watchdog that aborts the job with rsp_err=1.
module fact_bus_master #(
   parameter logic [7:0]  FACT_BASE   = 8'h20,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_n,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_err,
   fact_bus_master_if.master bus
);

   typedef enum logic [3:0] {
      StIdle, StReq1, StWOp, StWIen, StWStart, StRel, StWaitInt,
      StReq2, StRH, StRL, StWClr, StDone
   } state_t;

   if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
      $error("fact_bus_master: RD_LAT must be 1..3");
   end
   if (TIMEOUT_CYC == 0) begin : g_bad_timeout
      $error("fact_bus_master: TIMEOUT_CYC must be nonzero");
   end

   state_t      state_q;
   logic        m_req_q;
   logic        m_wr_q;
   logic [7:0]  m_address_q;
   logic [31:0] m_dout_q;
   logic [31:0] op_q;
   logic [1:0]  rd_cnt_q;
   logic        rsp_valid_q;
   logic [63:0] rsp_result_q;
   logic        xfer;
   logic        rd_last;
`ifdef FBM_TIMEOUT_EN
   logic [31:0] to_cnt_q;
   logic        err_q;
`endif

   assign xfer    = m_req_q & bus.M_grant;
   // A read completes on its RD_LAT-th granted cycle; M_din is sampled on that edge.
   assign rd_last = xfer && (rd_cnt_q == 2'(RD_LAT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         m_req_q      <= 1'b0;
         m_wr_q       <= 1'b0;
         m_address_q  <= 8'h00;
         m_dout_q     <= 32'h0;
         op_q         <= 32'h0;
         rd_cnt_q     <= 2'd0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 64'h0;
`ifdef FBM_TIMEOUT_EN
         to_cnt_q     <= 32'h0;
         err_q        <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: if (cmd_valid) begin
               op_q    <= cmd_n;
               m_req_q <= 1'b1;
               state_q <= StReq1;
`ifdef FBM_TIMEOUT_EN
               to_cnt_q <= 32'h0;
               err_q    <= 1'b0;
`endif
            end
            StReq1: if (bus.M_grant) begin
               m_wr_q      <= 1'b1;
               m_address_q <= FACT_BASE;
               m_dout_q    <= op_q;
               state_q     <= StWOp;
            end
            StWOp: if (xfer) begin
               m_address_q <= FACT_BASE + 8'h01;
               m_dout_q    <= 32'h1;
               state_q     <= StWIen;
            end
            StWIen: if (xfer) begin
               m_address_q <= FACT_BASE + 8'h03;
               m_dout_q    <= 32'h1;
               state_q     <= StWStart;
            end
            StWStart: if (xfer) begin
               m_req_q <= 1'b0;
               m_wr_q  <= 1'b0;
               state_q <= StRel;
            end
            StRel: state_q <= StWaitInt;
            StWaitInt: begin
               if (bus.f_interrupt) begin
                  m_req_q <= 1'b1;
                  state_q <= StReq2;
               end
`ifdef FBM_TIMEOUT_EN
               else if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
                  // Abort: skip the result reads, still clear the interrupt in the core.
                  m_req_q      <= 1'b1;
                  m_wr_q       <= 1'b1;
                  m_address_q  <= FACT_BASE + 8'h04;
                  m_dout_q     <= 32'h1;
                  rsp_result_q <= 64'h0;
                  err_q        <= 1'b1;
                  state_q      <= StWClr;
               end else begin
                  to_cnt_q <= to_cnt_q + 32'h1;
               end
`endif
            end
            StReq2: if (bus.M_grant) begin
               m_wr_q      <= 1'b0;
               m_address_q <= FACT_BASE + 8'h05;
               rd_cnt_q    <= 2'd0;
               state_q     <= StRH;
            end
            StRH: if (rd_last) begin
               rsp_result_q[63:32] <= bus.M_din;
               rd_cnt_q            <= 2'd0;
               m_address_q         <= FACT_BASE + 8'h06;
               state_q             <= StRL;
            end else if (xfer) begin
               rd_cnt_q <= rd_cnt_q + 2'd1;
            end
            StRL: if (rd_last) begin
               rsp_result_q[31:0] <= bus.M_din;
               rd_cnt_q           <= 2'd0;
               m_wr_q             <= 1'b1;
               m_address_q        <= FACT_BASE + 8'h04;
               m_dout_q           <= 32'h1;
               state_q            <= StWClr;
            end else if (xfer) begin
               rd_cnt_q <= rd_cnt_q + 2'd1;
            end
            StWClr: if (xfer) begin
               m_req_q     <= 1'b0;
               m_wr_q      <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready     = (state_q == StIdle);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_result    = rsp_result_q;
   assign bus.M_req     = m_req_q;
   assign bus.M_wr      = m_wr_q;
   assign bus.M_address = m_address_q;
   assign bus.M_dout    = m_dout_q;
`ifdef FBM_TIMEOUT_EN
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fact_bus_master.sv
// Directed bench for fact_bus_master with a behavioural factorial-core slave and a scoreboard.
// Build with FBM_TIMEOUT_EN defined to also exercise the watchdog abort path.
module tb_fact_bus_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_n = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic        rsp_err;

   int vectors = 0;
   int miscompares = 0;

   fact_bus_master_if bus ();

`ifdef FBM_TIMEOUT_EN
   fact_bus_master #(.FACT_BASE(8'h20), .RD_LAT(1), .TIMEOUT_CYC(16)) dut (
`else
   fact_bus_master #(.FACT_BASE(8'h20), .RD_LAT(1)) dut (
`endif
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_n      (cmd_n),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Factorial core model and bus slave
   logic [31:0] op_reg;
   logic        ien;
   logic        core_busy;
   logic        core_done;
   int          core_cnt;
   int          core_delay = 6;
   logic [63:0] res;
   logic        irq_block = 1'b0;
   logic        drop_arm = 1'b0;
   int          gnt_low_cnt = 0;
   logic [39:0] wr_log[$];
   logic [7:0]  rd_log[$];

   logic [63:0] exp_result = 64'h0;
   logic        exp_err = 1'b0;

   function automatic logic [63:0] fact64(input logic [31:0] n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 64'(i);
      return r;
   endfunction

   assign bus.M_grant     = (gnt_low_cnt == 0);
   assign bus.f_interrupt = core_done & ien & ~irq_block;
   assign bus.M_din       = (bus.M_address == 8'h25) ? res[63:32] :
                            (bus.M_address == 8'h26) ? res[31:0] : 32'h0;

   always @(posedge clk) begin
      if (reset) begin
         op_reg <= 32'h0; ien <= 1'b0; core_busy <= 1'b0; core_done <= 1'b0;
         core_cnt <= 0; res <= 64'h0; gnt_low_cnt <= 0;
      end else begin
         if (bus.M_req && bus.M_grant && bus.M_wr) begin
            wr_log.push_back({bus.M_address, bus.M_dout});
            case (bus.M_address)
               8'h20: op_reg <= bus.M_dout;
               8'h21: ien <= bus.M_dout[0];
               8'h23: begin
                  core_busy <= 1'b1; core_done <= 1'b0;
                  core_cnt <= core_delay; res <= fact64(op_reg);
               end
               8'h24: core_done <= 1'b0;
               default: ;
            endcase
         end
         if (bus.M_req && bus.M_grant && !bus.M_wr) rd_log.push_back(bus.M_address);
         if (core_busy) begin
            if (core_cnt <= 1) begin
               core_busy <= 1'b0; core_done <= 1'b1;
            end else begin
               core_cnt <= core_cnt - 1;
            end
         end
         if (drop_arm && gnt_low_cnt == 0 && bus.M_req && bus.M_grant && bus.M_wr &&
             bus.M_address == 8'h20)
            gnt_low_cnt <= 5;
         else if (gnt_low_cnt != 0)
            gnt_low_cnt <= gnt_low_cnt - 1;
      end
   end

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check64(name, {63'h0, act}, {63'h0, exp});
   endtask

   // Per-cycle compare process
   logic        prev_valid = 1'b0;
   logic [63:0] prev_result = 64'h0;
   logic        hs_q = 1'b0;

   always @(posedge clk) hs_q <= reset | (rsp_valid & rsp_ready);

   always @(negedge clk) begin
      if (!reset) begin
         if (core_busy) check1("bus_released_while_core_busy", bus.M_req, 1'b0);
         if (rsp_valid) begin
            check64("rsp_result", rsp_result, exp_result);
            check1("rsp_err", rsp_err, exp_err);
            check1("cmd_ready_while_rsp", cmd_ready, 1'b0);
         end
         if (prev_valid && !hs_q) begin
            check1("rsp_valid_hold", rsp_valid, 1'b1);
            check64("rsp_result_stable", rsp_result, prev_result);
         end
      end
      prev_valid  <= rsp_valid;
      prev_result <= rsp_result;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_job(input logic [31:0] n);
      int k;
      k = 0;
      wr_log.delete();
      rd_log.delete();
      exp_result = fact64(n);
      exp_err    = 1'b0;
      cmd_n      = n;
      cmd_valid  = 1'b1;
      while (cmd_ready !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check1("cmd_accept", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      int k;
      k = 0;
      while (rsp_valid !== 1'b1 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check1({name, "_rsp_arrived"}, rsp_valid, 1'b1);
   endtask

   task automatic check_bus(input logic [31:0] n, input bit with_reads);
      logic [39:0] exp_w[4];
      int i25, i26;
      exp_w[0] = {8'h20, n};
      exp_w[1] = {8'h21, 32'h1};
      exp_w[2] = {8'h23, 32'h1};
      exp_w[3] = {8'h24, 32'h1};
      check64("write_count", 64'(wr_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < wr_log.size(); i++)
         check64($sformatf("write%0d", i), 64'(wr_log[i]), 64'(exp_w[i]));
      if (with_reads) begin
         i25 = -1;
         i26 = -1;
         foreach (rd_log[i]) begin
            if (rd_log[i] == 8'h25) i25 = i;
            if (rd_log[i] == 8'h26 && i26 < 0) i26 = i;
         end
         check1("reads_25_then_26", (i25 >= 0 && i26 > i25), 1'b1);
      end
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check1("rsp_valid_after_hs", rsp_valid, 1'b0);
      check1("cmd_ready_after_hs", cmd_ready, 1'b1);
   endtask

   initial begin
      int k;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check1("reset_cmd_ready", cmd_ready, 1'b1);
      check1("reset_m_req", bus.M_req, 1'b0);
      check1("reset_m_wr", bus.M_wr, 1'b0);
      check64("reset_m_address", 64'(bus.M_address), 64'h0);
      check64("reset_m_dout", 64'(bus.M_dout), 64'h0);
      check1("reset_rsp_valid", rsp_valid, 1'b0);
      check1("reset_rsp_err", rsp_err, 1'b0);
      check64("reset_rsp_result", rsp_result, 64'h0);

      // Basic job, grant always high
      start_job(32'd4);
      wait_rsp("n4");
      check64("n4_literal", rsp_result, 64'h18);
      check_bus(32'd4, 1'b1);
      finish_rsp();

      // Large operand, rsp_ready already high at DONE entry
      rsp_ready = 1'b1;
      start_job(32'd20);
      wait_rsp("n20");
      check64("n20_literal", rsp_result, 64'h21C3677C82B40000);
      check1("n20_err", rsp_err, 1'b0);
      @(negedge clk);
      check1("n20_one_cycle_valid", rsp_valid, 1'b0);
      check1("n20_back_idle", cmd_ready, 1'b1);
      rsp_ready = 1'b0;
      check_bus(32'd20, 1'b1);

      // Grant withdrawn for 5 cycles while the INTR_EN write is pending
      drop_arm = 1'b1;
      start_job(32'd10);
      k = 0;
      while (wr_log.size() < 1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         check64("grant_stall_hold", {bus.M_grant, bus.M_req, bus.M_wr, bus.M_address},
                 {1'b0, 1'b1, 1'b1, 8'h21});
         @(negedge clk);
      end
      drop_arm = 1'b0;
      wait_rsp("n10");
      check64("n10_literal", rsp_result, 64'h375F00);
      check_bus(32'd10, 1'b1);
      finish_rsp();

      // Slow consumer with a competing command held high
      start_job(32'd6);
      wait_rsp("n6");
      check64("n6_literal", rsp_result, 64'h2D0);
      cmd_n = 32'd7;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check1("busy_cmd_ready_low", cmd_ready, 1'b0);
      end
      finish_rsp();
      start_job(32'd7);
      wait_rsp("n7");
      check64("n7_literal", rsp_result, 64'h13B0);
      check_bus(32'd7, 1'b1);
      finish_rsp();

      // Reset while waiting for the interrupt
      core_delay = 30;
      start_job(32'd5);
      k = 0;
      while (!core_busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check1("midreset_m_req", bus.M_req, 1'b0);
      check1("midreset_cmd_ready", cmd_ready, 1'b1);
      check1("midreset_rsp_valid", rsp_valid, 1'b0);
      core_delay = 6;
      start_job(32'd4);
      wait_rsp("after_reset");
      check64("after_reset_literal", rsp_result, 64'h18);
      check_bus(32'd4, 1'b1);
      finish_rsp();

`ifdef FBM_TIMEOUT_EN
      // Interrupt never arrives: watchdog abort
      irq_block = 1'b1;
      start_job(32'd9);
      exp_result = 64'h0;
      exp_err    = 1'b1;
      wait_rsp("timeout");
      check1("timeout_err", rsp_err, 1'b1);
      check64("timeout_result", rsp_result, 64'h0);
      check_bus(32'd9, 1'b0);
      finish_rsp();
      irq_block = 1'b0;
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d expected to end earlier",
               vectors);
      $fatal(1, "watchdog expired");
   end

endmodule
